// File: rtl/adder_bist_pkg.sv
// Shared types and helpers for the adder BIST checker.
package adder_bist_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } bist_state_e;

    // Widest operand the reference adder supports.
    localparam int unsigned MAXW = 32;

    // Width of the {a,b,cin} vector counter for a given operand width.
    function automatic int unsigned vecw(input int unsigned w);
        return 2 * w + 1;
    endfunction

    // Untruncated reference sum: {cout,sum} = a + b + cin.
    function automatic logic [MAXW:0] exp_add(input logic [MAXW-1:0] a,
                                              input logic [MAXW-1:0] b,
                                              input logic            cin);
        return {1'b0, a} + {1'b0, b} + {{MAXW{1'b0}}, cin};
    endfunction

endpackage

// File: rtl/adder_bist_checker_delay_line.sv
// Aligns {valid,expected,vector} with the DUT pipeline; DEPTH=0 is a wire.
module bist_delay_line #(
    parameter int unsigned DEPTH = 0,
    parameter int unsigned DW    = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout
);

    if (DEPTH == 0) begin : g_pass
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ rst;
        assign dout = din;
    end else begin : g_shift
        logic [DW-1:0] stage_q [DEPTH];

        // Shift one stage per clock; reset flushes every entry to invalid.
        always_ff @(posedge clk) begin
            if (rst) begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    stage_q[i] <= '0;
                end
            end else begin
                stage_q[0] <= din;
                for (int unsigned i = 1; i < DEPTH; i++) begin
                    stage_q[i] <= stage_q[i-1];
                end
            end
        end

        assign dout = stage_q[DEPTH-1];
    end

endmodule

// File: rtl/adder_bist_checker.sv
// Exhaustive {a,b,cin} stimulus generator and response checker for adder cells.
module adder_bist_checker #(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned LATENCY = 0,
    parameter int unsigned ERRW    = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic [WIDTH-1:0]   dut_a,
    output logic [WIDTH-1:0]   dut_b,
    output logic               dut_cin,
    input  logic [WIDTH-1:0]   dut_sum,
    input  logic               dut_cout,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [ERRW-1:0]    err_count,
    output logic [2*WIDTH:0]   first_fail
);

    import adder_bist_pkg::*;

    localparam int unsigned VW  = vecw(WIDTH);
    localparam int unsigned DW  = 1 + (WIDTH + 1) + VW;
    localparam int unsigned DCW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [VW-1:0]  VEC_LAST  = '1;
    localparam logic [DCW-1:0] DRAIN_END = DCW'(LATENCY - 1);

    bist_state_e state_q, state_d;

    logic [VW-1:0]    vec_q, vec_d;
    logic [DCW-1:0]   drain_q, drain_d;
    logic [ERRW-1:0]  err_q, err_d;
    logic [VW-1:0]    ff_q, ff_d;
    logic             pass_q, pass_d;

    logic [MAXW:0]         exp_full;
    logic [MAXW-WIDTH-1:0] exp_hi_unused;
    logic [WIDTH:0]        exp_w;

    logic [DW-1:0]   dl_in, dl_out;
    logic            cmp_valid;
    logic [WIDTH:0]  cmp_exp;
    logic [VW-1:0]   cmp_vec;
    logic            mismatch;
    logic            start_run;

    // The applied vector is the counter itself, so dut_* are registered.
    assign dut_a   = vec_q[VW-1:WIDTH+1];
    assign dut_b   = vec_q[WIDTH:1];
    assign dut_cin = vec_q[0];

    assign exp_full = exp_add({{(MAXW-WIDTH){1'b0}}, dut_a},
                              {{(MAXW-WIDTH){1'b0}}, dut_b},
                              dut_cin);
    assign {exp_hi_unused, exp_w} = exp_full;

    assign dl_in = {(state_q == RUN), exp_w, vec_q};

    bist_delay_line #(
        .DEPTH (LATENCY),
        .DW    (DW)
    ) u_delay (
        .clk  (clk),
        .rst  (rst),
        .din  (dl_in),
        .dout (dl_out)
    );

    assign {cmp_valid, cmp_exp, cmp_vec} = dl_out;

    // Case-inequality so X/Z on the DUT response is reported as a mismatch.
    assign mismatch  = cmp_valid && ({dut_cout, dut_sum} !== cmp_exp);
    assign start_run = start && ((state_q == IDLE) || (state_q == DONE));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; start is only honoured from IDLE or DONE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (vec_q == VEC_LAST) state_d = (LATENCY > 0) ? DRAIN : DONE;
            DRAIN:   if (drain_q == DRAIN_END) state_d = DONE;
            DONE:    if (start) state_d = RUN;
            default: state_d = IDLE;
        endcase
    end

    // Status outputs decoded from the registered state.
    always_comb begin
        busy       = (state_q == RUN) || (state_q == DRAIN);
        done       = (state_q == DONE);
        pass       = pass_q;
        err_count  = err_q;
        first_fail = ff_q;
    end

    // Vector counter, drain timer, error count and first-fail capture.
    // The compare on the final drain edge lands in err_d before pass is sampled.
    always_comb begin
        vec_d   = vec_q;
        drain_d = drain_q;
        err_d   = err_q;
        ff_d    = ff_q;
        pass_d  = pass_q;
        if (start_run) begin
            vec_d  = '0;
            err_d  = '0;
            ff_d   = '0;
            pass_d = 1'b0;
        end else begin
            if (state_q == RUN) begin
                drain_d = '0;
                if (vec_q != VEC_LAST) begin
                    vec_d = vec_q + VW'(1);
                end
            end else if (state_q == DRAIN) begin
                drain_d = drain_q + DCW'(1);
            end
            if (mismatch) begin
                if (err_q != '1) begin
                    err_d = err_q + ERRW'(1);
                end
                if (err_q == '0) begin
                    ff_d = cmp_vec;
                end
            end
            if ((state_d == DONE) && (state_q != DONE)) begin
                pass_d = (err_d == '0);
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            vec_q   <= '0;
            drain_q <= '0;
            err_q   <= '0;
            ff_q    <= '0;
            pass_q  <= 1'b0;
        end else begin
            vec_q   <= vec_d;
            drain_q <= drain_d;
            err_q   <= err_d;
            ff_q    <= ff_d;
            pass_q  <= pass_d;
        end
    end

endmodule

// File: tb/tb_adder_bist_checker.sv
// Bench for adder_bist_checker: four checker instances driving behavioural adders.
module tb_adder_bist_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [3:0] start;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    // Fault masks XORed onto the response of the adders behind instances 0 and 2.
    logic [1:0] fm0 [8];
    logic [4:0] fm2 [512];

    // Per-instance status, zero-extended for uniform access.
    logic        busy_w [4];
    logic        done_w [4];
    logic        pass_w [4];
    logic [31:0] err_w  [4];
    logic [31:0] ff_w   [4];
    logic [31:0] dv_w   [4];

    // Instance 0: WIDTH=1, LATENCY=0, full adder with injectable faults.
    logic [0:0] a0, b0, s0;
    logic       cin0, co0;
    logic [7:0] e0;
    logic [2:0] f0;
    logic [1:0] r0;
    assign r0 = ({1'b0, a0} + {1'b0, b0} + {1'b0, cin0}) ^ fm0[{a0, b0, cin0}];
    assign {co0, s0} = r0;

    adder_bist_checker #(.WIDTH(1), .LATENCY(0), .ERRW(8)) u0 (
        .clk(clk), .rst(rst), .start(start[0]),
        .dut_a(a0), .dut_b(b0), .dut_cin(cin0), .dut_sum(s0), .dut_cout(co0),
        .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]),
        .err_count(e0), .first_fail(f0));

    // Instance 1: WIDTH=1, carry-out wired as a&b.
    logic [0:0] a1, b1, s1;
    logic       cin1, co1;
    logic [7:0] e1;
    logic [2:0] f1;
    assign s1  = a1 ^ b1 ^ cin1;
    assign co1 = a1[0] & b1[0];

    adder_bist_checker #(.WIDTH(1), .LATENCY(0), .ERRW(8)) u1 (
        .clk(clk), .rst(rst), .start(start[1]),
        .dut_a(a1), .dut_b(b1), .dut_cin(cin1), .dut_sum(s1), .dut_cout(co1),
        .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]),
        .err_count(e1), .first_fail(f1));

    // Instance 2: WIDTH=4, LATENCY=2, two-stage registered adder.
    logic [3:0] a2, b2, s2;
    logic       cin2, co2;
    logic [7:0] e2;
    logic [8:0] f2;
    logic [4:0] p1, p2;
    always @(posedge clk) begin
        p1 <= ({1'b0, a2} + {1'b0, b2} + {4'b0, cin2}) ^ fm2[{a2, b2, cin2}];
        p2 <= p1;
    end
    assign {co2, s2} = p2;

    adder_bist_checker #(.WIDTH(4), .LATENCY(2), .ERRW(8)) u2 (
        .clk(clk), .rst(rst), .start(start[2]),
        .dut_a(a2), .dut_b(b2), .dut_cin(cin2), .dut_sum(s2), .dut_cout(co2),
        .busy(busy_w[2]), .done(done_w[2]), .pass(pass_w[2]),
        .err_count(e2), .first_fail(f2));

    // Instance 3: WIDTH=4, LATENCY=0, ERRW=4, sum bit 0 stuck at 0.
    logic [3:0] a3, b3, s3;
    logic       cin3, co3;
    logic [3:0] e3;
    logic [8:0] f3;
    logic [4:0] r3;
    assign r3 = ({1'b0, a3} + {1'b0, b3} + {4'b0, cin3}) & 5'b11110;
    assign {co3, s3} = r3;

    adder_bist_checker #(.WIDTH(4), .LATENCY(0), .ERRW(4)) u3 (
        .clk(clk), .rst(rst), .start(start[3]),
        .dut_a(a3), .dut_b(b3), .dut_cin(cin3), .dut_sum(s3), .dut_cout(co3),
        .busy(busy_w[3]), .done(done_w[3]), .pass(pass_w[3]),
        .err_count(e3), .first_fail(f3));

    assign err_w[0] = {24'b0, e0};
    assign err_w[1] = {24'b0, e1};
    assign err_w[2] = {24'b0, e2};
    assign err_w[3] = {28'b0, e3};
    assign ff_w[0]  = {29'b0, f0};
    assign ff_w[1]  = {29'b0, f1};
    assign ff_w[2]  = {23'b0, f2};
    assign ff_w[3]  = {23'b0, f3};
    assign dv_w[0]  = {29'b0, a0, b0, cin0};
    assign dv_w[1]  = {29'b0, a1, b1, cin1};
    assign dv_w[2]  = {23'b0, a2, b2, cin2};
    assign dv_w[3]  = {23'b0, a3, b3, cin3};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int unsigned width_of(input int idx);
        return (idx < 2) ? 1 : 4;
    endfunction

    function automatic int unsigned lat_of(input int idx);
        return (idx == 2) ? 2 : 0;
    endfunction

    // Arithmetic truth for vector v = {a,b,cin}.
    function automatic int unsigned true_sum(input int unsigned w, input int unsigned v);
        int unsigned m = (1 << w) - 1;
        return ((v >> (w + 1)) & m) + ((v >> 1) & m) + (v & 1);
    endfunction

    // What each instance's adder actually returns for vector v.
    function automatic int unsigned dut_resp(input int idx, input int unsigned v);
        int unsigned w  = width_of(idx);
        int unsigned m  = (1 << w) - 1;
        int unsigned a  = (v >> (w + 1)) & m;
        int unsigned b  = (v >> 1) & m;
        int unsigned c  = v & 1;
        int unsigned t  = true_sum(w, v);
        logic [8:0]  vi = 9'(v);
        case (idx)
            0:       return t ^ 32'(fm0[vi[2:0]]);
            1:       return ((a & b) << 1) | ((a ^ b ^ c) & 1);
            2:       return t ^ 32'(fm2[vi]);
            default: return t & ~32'd1;
        endcase
    endfunction

    // Expected error count (saturating) and first failing vector for a whole run.
    task automatic ref_run(input int idx, output int unsigned e_err, output int unsigned e_ff);
        int unsigned w    = width_of(idx);
        int unsigned n    = 1 << (2 * w + 1);
        int unsigned emax = (idx == 3) ? 15 : 255;
        e_err = 0;
        e_ff  = 0;
        for (int unsigned v = 0; v < n; v++) begin
            if (dut_resp(idx, v) != true_sum(w, v)) begin
                if (e_err == 0) e_ff = v;
                if (e_err < emax) e_err++;
            end
        end
    endtask

    task automatic check_idle(input int idx, input string tag);
        check_eq({tag, "_busy"}, 32'(busy_w[idx]), 0);
        check_eq({tag, "_done"}, 32'(done_w[idx]), 0);
        check_eq({tag, "_pass"}, 32'(pass_w[idx]), 0);
        check_eq({tag, "_err"},  err_w[idx], 0);
        check_eq({tag, "_ff"},   ff_w[idx], 0);
        check_eq({tag, "_vec"},  dv_w[idx], 0);
    endtask

    // Start a run on instance idx and check sequence, timing and verdict.
    // mid_start>0 pulses start again at that cycle, which must be ignored.
    task automatic run_check(input int idx, input string tag, input int unsigned mid_start);
        int unsigned w   = width_of(idx);
        int unsigned n   = 1 << (2 * w + 1);
        int unsigned lat = lat_of(idx);
        int unsigned e_err, e_ff, cyc, busy_cnt, exp_v;
        bit seen;
        ref_run(idx, e_err, e_ff);
        @(negedge clk);
        start[idx] = 1'b1;
        @(negedge clk);
        start[idx] = 1'b0;
        cyc      = 1;
        busy_cnt = 0;
        seen     = 0;
        check_eq({tag, "_clr_done"}, 32'(done_w[idx]), 0);
        check_eq({tag, "_clr_pass"}, 32'(pass_w[idx]), 0);
        check_eq({tag, "_clr_err"},  err_w[idx], 0);
        check_eq({tag, "_clr_ff"},   ff_w[idx], 0);
        while (!seen && cyc < n + lat + 50) begin
            exp_v = (cyc - 1 < n) ? cyc - 1 : n - 1;
            check_eq($sformatf("%s_vec%0d", tag, cyc - 1), dv_w[idx], exp_v);
            if (busy_w[idx]) busy_cnt++;
            if (done_w[idx]) begin
                seen = 1;
            end else begin
                @(negedge clk);
                start[idx] = (cyc == mid_start);
                cyc++;
            end
        end
        start[idx] = 1'b0;
        check_eq({tag, "_done_seen"}, 32'(seen), 1);
        check_eq({tag, "_done_edge"}, cyc - 1, n + lat);
        check_eq({tag, "_busy_cycles"}, busy_cnt, n + lat);
        check_eq({tag, "_pass"}, 32'(pass_w[idx]), (e_err == 0) ? 1 : 0);
        check_eq({tag, "_err"}, err_w[idx], e_err);
        check_eq({tag, "_ff"}, ff_w[idx], e_ff);
        check_eq({tag, "_hold_vec"}, dv_w[idx], n - 1);
    endtask

    initial begin
        int unsigned cyc;
        rst   = 1'b1;
        start = '0;
        for (int i = 0; i < 8; i++) fm0[i] = '0;
        for (int i = 0; i < 512; i++) fm2[i] = '0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) check_idle(i, $sformatf("rst%0d", i));
        rst = 1'b0;

        run_check(0, "t1_fa", 0);
        run_check(1, "t2_cout_and", 0);
        run_check(2, "t3_rca_lat2", 0);
        run_check(3, "t4_sat", 0);

        // Random faults behind the pipelined adder, stray start mid-run, then clean restart.
        for (int i = 0; i < 512; i++) begin
            fm2[i] = ($urandom_range(0, 63) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
        end
        fm2[$urandom_range(0, 511)] = 5'($urandom_range(1, 31));
        run_check(2, "t6_rand", $urandom_range(5, 400));
        for (int i = 0; i < 512; i++) fm2[i] = '0;
        run_check(2, "t6_restart", 0);

        // Random fault patterns on the single full adder, each run restarted from DONE.
        for (int it = 0; it < 4; it++) begin
            for (int i = 0; i < 8; i++) begin
                fm0[i] = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            end
            run_check(0, $sformatf("rand_fa%0d", it), (it == 1) ? 3 : 0);
        end

        // Abort a run with reset at vector 5.
        for (int i = 0; i < 8; i++) fm0[i] = '0;
        fm0[1] = 2'b01;
        @(negedge clk);
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        cyc = 0;
        while (dv_w[0] != 5 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check_eq("t5_reach_vec5", dv_w[0], 5);
        check_eq("t5_err_before_rst", err_w[0], 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_idle(0, "t5_after_rst");
        repeat (3) @(negedge clk);
        check_eq("t5_stays_idle_busy", 32'(busy_w[0]), 0);
        check_eq("t5_stays_idle_done", 32'(done_w[0]), 0);
        fm0[1] = '0;
        run_check(0, "t5_fresh", 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
